// File: rtl/fetch_sequencer.sv
// Program-counter owner and instruction-memory sequencer: loads words as big-endian bytes in HALT,
// steps/branches/jumps the PC in RUN, and parks in a sticky FAULT on a bad load or fetch address.
module fetch_sequencer #(
  parameter int unsigned MEM_BYTES = 56,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        halt_req,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic        link,
  input  logic [25:0] jump_target,
  input  logic        load_valid,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic        load_ready,
  output logic [31:0] PC,
  output logic        fetch_valid,
  output logic        imem_we,
  output logic [31:0] imem_waddr,
  output logic [7:0]  imem_wdata,
  output logic        link_we,
  output logic [31:0] link_addr,
  output logic        fault,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    S_HALT  = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  // Highest byte address at which a whole 4-byte word still fits in memory.
  localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

  state_t      state_q;
  logic [31:0] pc_q;
  logic [1:0]  k_q;
  logic [31:0] data_q;
  logic        we_q;
  logic [31:0] waddr_q;
  logic [7:0]  wdata_q;
  logic        link_we_q;
  logic [31:0] link_addr_q;
  logic        fault_q;

  logic [31:0] pc_plus4;
  logic [31:0] br_target;
  logic [31:0] jmp_target;
  logic [31:0] pc_d;
  logic        pc_d_ok;
  logic        load_ok;

  assign pc_plus4   = pc_q + 32'd4;
  assign br_target  = pc_plus4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
  assign jmp_target = {pc_plus4[31:28], jump_target, 2'b00};

  always_comb begin
    pc_d = pc_plus4;
    if (jump)              pc_d = jmp_target;
    else if (branch_taken) pc_d = br_target;
  end

  // Compare against LAST_WORD rather than adding 3 so addresses near 2^32 cannot wrap into range.
  assign pc_d_ok = (pc_d[1:0] == 2'b00) && (pc_d <= LAST_WORD);
  assign load_ok = (load_addr[1:0] == 2'b00) && (load_addr <= LAST_WORD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_HALT;
      pc_q        <= RESET_PC;
      k_q         <= 2'd0;
      data_q      <= 32'd0;
      we_q        <= 1'b0;
      waddr_q     <= 32'd0;
      wdata_q     <= 8'd0;
      link_we_q   <= 1'b0;
      link_addr_q <= 32'd0;
      fault_q     <= 1'b0;
    end else begin
      link_we_q <= 1'b0;
      case (state_q)
        S_HALT: begin
          if (load_valid) begin
            if (load_ok) begin
              state_q <= S_LOAD;
              k_q     <= 2'd0;
              we_q    <= 1'b1;
              waddr_q <= load_addr;
              wdata_q <= load_data[31:24];
              data_q  <= {load_data[23:0], 8'h00};
            end else begin
              state_q <= S_FAULT;
              fault_q <= 1'b1;
            end
          end else if (start) begin
            state_q <= S_RUN;
          end
        end
        S_LOAD: begin
          // data_q shifts left so the next byte to emit is always in the top lane.
          if (k_q == 2'd3) begin
            state_q <= S_HALT;
            we_q    <= 1'b0;
          end else begin
            k_q     <= k_q + 2'd1;
            waddr_q <= waddr_q + 32'd1;
            wdata_q <= data_q[31:24];
            data_q  <= {data_q[23:0], 8'h00};
          end
        end
        S_RUN: begin
          if (halt_req) begin
            state_q <= S_HALT;
          end else if (!stall) begin
            if (pc_d_ok) begin
              pc_q <= pc_d;
              if (jump && link) begin
                link_we_q   <= 1'b1;
                link_addr_q <= pc_plus4;
              end
            end else begin
              state_q <= S_FAULT;
              fault_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign state       = state_q;
  assign PC          = pc_q;
  assign load_ready  = (state_q == S_HALT);
  assign fetch_valid = (state_q == S_RUN) && !stall;
  assign imem_we     = we_q;
  assign imem_waddr  = waddr_q;
  assign imem_wdata  = wdata_q;
  assign link_we     = link_we_q;
  assign link_addr   = link_addr_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios with literal expectations, then randomized episodes
// checked every cycle against a byte-queue / PC-arithmetic reference model.
module tb_fetch_sequencer;

  localparam int unsigned MEM = 56;

  logic        clk;
  logic        reset;
  logic        start, halt_req, stall, branch_taken, jump, link, load_valid;
  logic [15:0] branch_offset;
  logic [25:0] jump_target;
  logic [31:0] load_addr, load_data;
  logic        load_ready, fetch_valid, imem_we, link_we, fault;
  logic [31:0] PC, imem_waddr, link_addr;
  logic [7:0]  imem_wdata;
  logic [1:0]  state;

  fetch_sequencer #(.MEM_BYTES(MEM), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .start(start), .halt_req(halt_req), .stall(stall),
    .branch_taken(branch_taken), .branch_offset(branch_offset), .jump(jump), .link(link),
    .jump_target(jump_target), .load_valid(load_valid), .load_addr(load_addr),
    .load_data(load_data), .load_ready(load_ready), .PC(PC), .fetch_valid(fetch_valid),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .link_we(link_we),
    .link_addr(link_addr), .fault(fault), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode uses the externally visible state numbering.
  int          m_mode;
  logic [31:0] m_pc;
  logic        m_fault;
  logic        m_lwe;
  logic [31:0] m_laddr;
  logic [31:0] q_addr[$];
  logic [7:0]  q_dat[$];
  logic [31:0] m_pc4, m_np;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode = 0; m_pc = 0; m_fault = 0; m_lwe = 0; m_laddr = 0;
      q_addr.delete(); q_dat.delete();
    end else begin
      m_lwe = 0;
      case (m_mode)
        0: begin
          if (load_valid) begin
            if (load_addr % 4 == 0 && longint'(load_addr) + 3 < longint'(MEM)) begin
              for (int b = 0; b < 4; b++) begin
                q_addr.push_back(load_addr + b);
                q_dat.push_back(8'(load_data >> (24 - 8 * b)));
              end
              m_mode = 1;
            end else begin
              m_mode = 3; m_fault = 1;
            end
          end else if (start) m_mode = 2;
        end
        1: begin
          void'(q_addr.pop_front());
          void'(q_dat.pop_front());
          if (q_addr.size() == 0) m_mode = 0;
        end
        2: begin
          if (halt_req) m_mode = 0;
          else if (!stall) begin
            m_pc4 = m_pc + 32'd4;
            if (jump) m_np = (m_pc4 & 32'hF000_0000) | (32'(jump_target) * 32'd4);
            else if (branch_taken) m_np = m_pc4 + 32'(int'($signed(branch_offset)) * 4);
            else m_np = m_pc4;
            if (m_np % 4 == 0 && longint'(m_np) + 3 < longint'(MEM)) begin
              m_pc = m_np;
              if (jump && link) begin m_lwe = 1; m_laddr = m_pc4; end
            end else begin
              m_mode = 3; m_fault = 1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      chk("state", 32'(state), 32'(m_mode));
      chk("pc", PC, m_pc);
      chk("fault", 32'(fault), 32'(m_fault));
      chk("load_ready", 32'(load_ready), 32'(m_mode == 0));
      chk("fetch_valid", 32'(fetch_valid), 32'(m_mode == 2 && !stall));
      chk("imem_we", 32'(imem_we), 32'(m_mode == 1));
      if (m_mode == 1 && q_addr.size() > 0) begin
        chk("imem_waddr", imem_waddr, q_addr[0]);
        chk("imem_wdata", 32'(imem_wdata), 32'(q_dat[0]));
      end
      chk("link_we", 32'(link_we), 32'(m_lwe));
      chk("link_addr", link_addr, m_laddr);
    end
  end

  task automatic clr();
    start = 0; halt_req = 0; stall = 0; branch_taken = 0; branch_offset = 0;
    jump = 0; link = 0; jump_target = 0; load_valid = 0; load_addr = 0; load_data = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after a rising edge; completes before the next falling edge.
  task automatic do_reset();
    reset = 0;
    #2;
    reset = 1;
  endtask

  logic [7:0]  exp_b[4];
  logic [31:0] exp_pc[7];

  initial begin
    clr();
    reset = 1;
    #2 reset = 0;
    #2;
    chk("rst_state", 32'(state), 0);
    chk("rst_pc", PC, 0);
    chk("rst_load_ready", 32'(load_ready), 1);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_imem_we", 32'(imem_we), 0);
    chk("rst_fetch_valid", 32'(fetch_valid), 0);
    chk("rst_link_we", 32'(link_we), 0);
    chk("rst_link_addr", link_addr, 0);
    chk("rst_waddr", imem_waddr, 0);
    chk("rst_wdata", 32'(imem_wdata), 0);
    step(); step();
    reset = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_state", 32'(state), 0);
      chk("idle_load_ready", 32'(load_ready), 1);
      chk("idle_imem_we", 32'(imem_we), 0);
    end

    // Word load at byte 8.
    exp_b[0] = 8'h8C; exp_b[1] = 8'h65; exp_b[2] = 8'h00; exp_b[3] = 8'h00;
    load_valid = 1; load_addr = 32'd8; load_data = 32'h8C65_0000;
    step();
    clr();
    for (int k = 0; k < 4; k++) begin
      chk("ld_we", 32'(imem_we), 1);
      chk("ld_waddr", imem_waddr, 32'(8 + k));
      chk("ld_wdata", 32'(imem_wdata), 32'(exp_b[k]));
      chk("ld_ready", 32'(load_ready), 0);
      step();
    end
    chk("ld_done_state", 32'(state), 0);
    chk("ld_done_we", 32'(imem_we), 0);

    // Misaligned load faults without writing.
    load_valid = 1; load_addr = 32'd10; load_data = 32'h1234_5678;
    step();
    clr();
    chk("bad_ld_state", 32'(state), 3);
    chk("bad_ld_fault", 32'(fault), 1);
    chk("bad_ld_we", 32'(imem_we), 0);
    step();
    chk("fault_sticky", 32'(state), 3);
    do_reset();

    // Sequential run with one stalled cycle.
    exp_pc = '{32'd0, 32'd4, 32'd8, 32'd8, 32'd12, 32'd16, 32'd20};
    start = 1;
    step();
    start = 0;
    for (int i = 0; i < 7; i++) begin
      chk("seq_pc", PC, exp_pc[i]);
      stall = (i == 2);
      #1;
      chk("seq_fetch_valid", 32'(fetch_valid), 32'(i != 2));
      if (i < 6) step();
    end
    stall = 0;

    jump = 1; jump_target = 26'd6; step(); clr();
    chk("jump_pc", PC, 24);
    step();
    chk("seq_pc28", PC, 28);
    branch_taken = 1; branch_offset = 16'd1; step(); clr();
    chk("branch_pc", PC, 36);
    jump = 1; jump_target = 26'd7; step(); clr();
    chk("jump_back_pc", PC, 28);
    jump = 1; jump_target = 26'd3; branch_taken = 1; branch_offset = 16'd1; step(); clr();
    chk("jump_wins_pc", PC, 12);
    halt_req = 1; stall = 1; step(); clr();
    chk("halt_state", 32'(state), 0);
    chk("halt_pc", PC, 12);
    start = 1; step(); clr();
    chk("restart_state", 32'(state), 2);
    jump = 1; jump_target = 26'd13; step(); clr();
    chk("pc52", PC, 52);
    jump = 1; link = 1; jump_target = 26'd0; step(); clr();
    chk("jal_pc", PC, 0);
    chk("jal_link_we", 32'(link_we), 1);
    chk("jal_link_addr", link_addr, 56);
    step();
    chk("jal_pulse_end", 32'(link_we), 0);
    chk("after_jal_pc", PC, 4);
    jump = 1; jump_target = 26'd13; step(); clr();
    step();
    chk("oob_state", 32'(state), 3);
    chk("oob_pc", PC, 52);
    chk("oob_fault", 32'(fault), 1);
    chk("model_pc_pin", m_pc, 52);
    chk("model_mode_pin", 32'(m_mode), 3);

    // Reset while writing byte k=2.
    do_reset();
    load_valid = 1; load_addr = 32'd0; load_data = $urandom;
    step(); clr();
    step(); step();
    chk("mid_ld_we", 32'(imem_we), 1);
    chk("mid_ld_waddr", imem_waddr, 2);
    #2 reset = 0;
    #1;
    chk("async_we_drop", 32'(imem_we), 0);
    reset = 1;
    step();
    chk("post_rst_state", 32'(state), 0);
    chk("post_rst_we", 32'(imem_we), 0);

    // Randomized episodes, each starting from reset.
    for (int ep = 0; ep < 30; ep++) begin
      do_reset();
      for (int c = 0; c < 200; c++) begin
        load_valid    = ($urandom_range(0, 99) < 25);
        load_addr     = ($urandom_range(0, 99) < 80) ? 32'($urandom_range(0, 15) * 4)
                                                      : 32'($urandom_range(0, 63));
        load_data     = $urandom;
        start         = ($urandom_range(0, 99) < 15);
        halt_req      = ($urandom_range(0, 99) < 4);
        stall         = ($urandom_range(0, 99) < 20);
        jump          = ($urandom_range(0, 99) < 12);
        link          = $urandom_range(0, 1) == 1;
        jump_target   = 26'($urandom_range(0, 15));
        branch_taken  = ($urandom_range(0, 99) < 15);
        branch_offset = 16'(int'($urandom_range(0, 10)) - 6);
        step();
      end
      clr();
    end

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
